// File: rtl/mmio_responder_pkg.sv
// Register offsets, bit positions and reset values for the MMIO responder.
package mmio_responder_pkg;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h1;
    localparam logic [3:0] OFF_COMPARE = 4'h2;
    localparam logic [3:0] OFF_STATUS  = 4'h3;
    localparam logic [3:0] OFF_TXDATA  = 4'h4;
    localparam logic [3:0] OFF_GPIO    = 4'h5;

    localparam int ST_MATCH    = 0;
    localparam int ST_OVERFLOW = 3;

    localparam logic [15:0] COMPARE_RST = 16'hFFFF;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic timer_en;
    } ctrl_t;

    function automatic logic [15:0] pack_status(
        input logic [4:0] level,
        input logic       overflow,
        input logic       empty,
        input logic       full,
        input logic       match
    );
        return {7'b0, level, overflow, empty, full, match};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; push into a full FIFO succeeds
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// 16-word MMIO window on the core data port: control, timer with compare
// interrupt, GPIO output and a transmit FIFO.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'hFF0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        sel,
    output logic [15:0] rdata,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] gpio_out,
    output logic        irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    ctrl_t       ctrl_q, ctrl_d;
    logic [15:0] count_q, count_d;
    logic [15:0] compare_q, compare_d;
    logic [15:0] gpio_q, gpio_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;

    logic [3:0]    off;
    logic          wr_en;
    logic          wr_status;
    logic          wr_tx;
    logic          hit;
    logic          ovf_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    assign sel       = (addr[15:4] == BASE_ADDR);
    assign off       = addr[3:0];
    assign wr_en     = sel & mem_write;
    assign wr_status = wr_en & (off == OFF_STATUS);
    assign wr_tx     = wr_en & (off == OFF_TXDATA);

    // A full FIFO still takes a push when the consumer drains the head.
    assign ovf_set  = wr_tx & fifo_full & ~tx_ready;
    assign hit      = ctrl_q.timer_en & (count_q == compare_q);
    assign tx_valid = ~fifo_empty;
    assign gpio_out = gpio_q;
    assign irq      = match_q & ctrl_q.irq_en;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (tx_ready),
        .din   (wdata),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        compare_d = compare_q;
        gpio_d    = gpio_q;
        count_d   = count_q;
        if (wr_en && off == OFF_CTRL)    ctrl_d    = ctrl_t'(wdata[2:0]);
        if (wr_en && off == OFF_COMPARE) compare_d = wdata;
        if (wr_en && off == OFF_GPIO)    gpio_d    = wdata;
        if (wr_en && off == OFF_COUNT) begin
            count_d = wdata;
        end else if (ctrl_q.timer_en) begin
            count_d = (hit & ctrl_q.auto_reload) ? 16'h0 : count_q + 16'h1;
        end
        match_d = hit | (match_q & ~(wr_status & wdata[ST_MATCH]));
        ovf_d   = ovf_set | (ovf_q & ~(wr_status & wdata[ST_OVERFLOW]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            gpio_q    <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            gpio_q    <= gpio_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && mem_read) begin
            case (off)
                OFF_CTRL:    rdata = {13'b0, ctrl_q};
                OFF_COUNT:   rdata = count_q;
                OFF_COMPARE: rdata = compare_q;
                OFF_STATUS:  rdata = pack_status(5'(fifo_level), ovf_q,
                                                 fifo_empty, fifo_full,
                                                 match_q);
                OFF_GPIO:    rdata = gpio_q;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: register map, timer, TX FIFO
// with a scoreboard queue for drained data.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        sel;
    logic [15:0] rdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] gpio_out;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] sb[$];

    mmio_responder dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .sel       (sel),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        addr     = a;
        mem_read = 1'b1;
        #1;
        d        = rdata;
        mem_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        logic [15:0] exp_tab [16];
        for (int i = 0; i < 16; i++) exp_tab[i] = 16'h0;
        exp_tab[2] = 16'hFFFF;
        exp_tab[3] = 16'h0004;
        for (int i = 0; i < 16; i++) begin
            rd(16'hFF00 | 16'(i), v);
            total_cnt++;
            if (v !== exp_tab[i])
                $display("FAIL reset_reg[%0d]: got %h expected %h", i, v, exp_tab[i]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({irq, tx_valid, tx_data, gpio_out} !== 34'h0)
            $display("FAIL reset_outs: got %b%b %h %h expected 00 0000 0000",
                     irq, tx_valid, tx_data, gpio_out);
        else pass_cnt++;
    endtask

    task automatic test_timer_reload();
        logic [15:0] v;
        wr(16'hFF02, 16'd5);
        wr(16'hFF00, 16'h0007);
        for (int i = 0; i <= 5; i++) begin
            rd(16'hFF01, v);
            total_cnt++;
            if (v !== 16'(i) || irq !== 1'b0)
                $display("FAIL timer_count[%0d]: got %h irq %b expected %h irq 0", i, v, irq, 16'(i));
            else pass_cnt++;
            step();
        end
        rd(16'hFF01, v);
        total_cnt++;
        if (v !== 16'h0 || irq !== 1'b1)
            $display("FAIL timer_match: got count %h irq %b expected 0000 irq 1", v, irq);
        else pass_cnt++;
        rd(16'hFF03, v);
        total_cnt++;
        if (v !== 16'h0005)
            $display("FAIL timer_status: got %h expected 0005", v);
        else pass_cnt++;
        wr(16'hFF03, 16'h0001);
        total_cnt++;
        if (irq !== 1'b0)
            $display("FAIL timer_w1c: got irq %b expected 0", irq);
        else pass_cnt++;
        wr(16'hFF00, 16'h0000);
    endtask

    task automatic test_timer_precedence();
        logic [15:0] v;
        wr(16'hFF02, 16'h0010);
        wr(16'hFF01, 16'h0010);
        wr(16'hFF00, 16'h0001);
        wr(16'hFF03, 16'h0001);
        rd(16'hFF03, v);
        total_cnt++;
        if (v[0] !== 1'b1)
            $display("FAIL set_beats_w1c: got match %b expected 1", v[0]);
        else pass_cnt++;
        wr(16'hFF03, 16'h0001);
        rd(16'hFF03, v);
        total_cnt++;
        if (v[0] !== 1'b0)
            $display("FAIL w1c_clear: got match %b expected 0", v[0]);
        else pass_cnt++;
        wr(16'hFF02, 16'h1234);
        wr(16'hFF01, 16'hFFFE);
        rd(16'hFF01, v);
        total_cnt++;
        if (v !== 16'hFFFE)
            $display("FAIL count_write: got %h expected fffe", v);
        else pass_cnt++;
        step();
        rd(16'hFF01, v);
        total_cnt++;
        if (v !== 16'hFFFF)
            $display("FAIL count_ffff: got %h expected ffff", v);
        else pass_cnt++;
        step();
        rd(16'hFF01, v);
        total_cnt++;
        if (v !== 16'h0000)
            $display("FAIL count_wrap: got %h expected 0000", v);
        else pass_cnt++;
        wr(16'hFF00, 16'h0000);
    endtask

    task automatic drain(input string name);
        tx_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            logic [15:0] e;
            e = sb.pop_front();
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== e)
                $display("FAIL %s: got v%b %h expected v1 %h", name, tx_valid, tx_data, e);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (sb.size() != 0 || tx_valid !== 1'b0)
            $display("FAIL %s_empty: got tx_valid %b left %0d expected 0", name, tx_valid, sb.size());
        else pass_cnt++;
        tx_ready = 1'b0;
    endtask

    task automatic test_fifo_overflow();
        logic [15:0] v;
        int lvl;
        lvl = 0;
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr(16'hFF04, 16'hA001 + 16'(k));
            if (lvl < 4) begin
                sb.push_back(16'hA001 + 16'(k));
                lvl++;
            end
        end
        rd(16'hFF03, v);
        total_cnt++;
        if (v !== 16'h004A)
            $display("FAIL fifo_full_status: got %h expected 004a", v);
        else pass_cnt++;
        step();
        total_cnt++;
        if (tx_data !== sb[0])
            $display("FAIL fifo_hold: got %h expected %h", tx_data, sb[0]);
        else pass_cnt++;
        wr(16'hFF03, 16'h0008);
        rd(16'hFF03, v);
        total_cnt++;
        if (v !== 16'h0042)
            $display("FAIL ovf_w1c: got %h expected 0042", v);
        else pass_cnt++;
        drain("fifo_drain");
        rd(16'hFF03, v);
        total_cnt++;
        if (v !== 16'h0004)
            $display("FAIL fifo_empty_status: got %h expected 0004", v);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] v;
        logic [15:0] e;
        for (int k = 0; k < 4; k++) begin
            wr(16'hFF04, 16'hB001 + 16'(k));
            sb.push_back(16'hB001 + 16'(k));
        end
        addr      = 16'hFF04;
        wdata     = 16'hB005;
        mem_write = 1'b1;
        tx_ready  = 1'b1;
        #1;
        e = sb.pop_front();
        sb.push_back(16'hB005);
        total_cnt++;
        if (tx_data !== e)
            $display("FAIL pushpop_head: got %h expected %h", tx_data, e);
        else pass_cnt++;
        step();
        mem_write = 1'b0;
        tx_ready  = 1'b0;
        rd(16'hFF03, v);
        total_cnt++;
        if (v !== 16'h0042)
            $display("FAIL pushpop_status: got %h expected 0042", v);
        else pass_cnt++;
        drain("pushpop_drain");
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr(16'hFF04, 16'hC001 + 16'(k));
            sb.push_back(16'hC001 + 16'(k));
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== sb[0])
                $display("FAIL b2b[%0d]: got v%b %h expected v1 %h", k, tx_valid, tx_data, sb[0]);
            else pass_cnt++;
            void'(sb.pop_front());
        end
        step();
        total_cnt++;
        if (tx_valid !== 1'b0)
            $display("FAIL b2b_empty: got %b expected 0", tx_valid);
        else pass_cnt++;
        tx_ready = 1'b0;
    endtask

    task automatic test_decode();
        logic [15:0] v;
        addr      = 16'h1234;
        wdata     = 16'hFFFF;
        mem_write = 1'b1;
        #1;
        total_cnt++;
        if (sel !== 1'b0)
            $display("FAIL decode_sel: got %b expected 0", sel);
        else pass_cnt++;
        step();
        mem_write = 1'b0;
        rd(16'h1234, v);
        total_cnt++;
        if (v !== 16'h0)
            $display("FAIL decode_rdata: got %h expected 0000", v);
        else pass_cnt++;
        rd(16'hFF05, v);
        total_cnt++;
        if (v !== 16'h0 || gpio_out !== 16'h0)
            $display("FAIL decode_nochange: got %h/%h expected 0000", v, gpio_out);
        else pass_cnt++;
        wr(16'hFF05, 16'h5A5A);
        total_cnt++;
        if (gpio_out !== 16'h5A5A)
            $display("FAIL gpio_out: got %h expected 5a5a", gpio_out);
        else pass_cnt++;
        wr(16'hFF0A, 16'hBEEF);
        rd(16'hFF0A, v);
        total_cnt++;
        if (v !== 16'h0)
            $display("FAIL reserved: got %h expected 0000", v);
        else pass_cnt++;
        rd(16'hFF04, v);
        total_cnt++;
        if (v !== 16'h0)
            $display("FAIL txdata_read: got %h expected 0000", v);
        else pass_cnt++;
        addr = 16'hFF05;
        #1;
        total_cnt++;
        if (rdata !== 16'h0)
            $display("FAIL no_read_strobe: got %h expected 0000", rdata);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [15:0] v;
        wr(16'hFF00, 16'h0001);
        wr(16'hFF04, 16'hD001);
        wr(16'hFF04, 16'hD002);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(16'hFF03, v);
        total_cnt++;
        if (v !== 16'h0004 || tx_valid !== 1'b0 || tx_data !== 16'h0)
            $display("FAIL mid_reset_fifo: got %h v%b %h expected 0004 v0 0000", v, tx_valid, tx_data);
        else pass_cnt++;
        step();
        rd(16'hFF01, v);
        total_cnt++;
        if (v !== 16'h0 || gpio_out !== 16'h0)
            $display("FAIL mid_reset_regs: got count %h gpio %h expected 0000", v, gpio_out);
        else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 16'h0;
        wdata     = 16'h0;
        tx_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_timer_reload();
        test_timer_precedence();
        test_fifo_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_decode();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
